// File: rtl/dram_seq_pkg.sv
// rtl/dram_seq_pkg.sv - state encoding, default cycle counts and output decode for the DRAM reset sequencer
package dram_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOCK_WAIT  = 3'd1,
        ST_RESET_HOLD = 3'd2,
        ST_CKE_WAIT   = 3'd3,
        ST_RUN        = 3'd4
    } state_e;

    localparam int DEF_LOCK_CYCLES  = 1000;
    localparam int DEF_RESET_CYCLES = 20000;
    localparam int DEF_CKE_CYCLES   = 40000;

    typedef struct packed {
        logic dram_rst;
        logic ddr_reset_n;
        logic ddr_cke;
        logic init_done;
    } pins_t;

    localparam pins_t PINS_RESET = '{dram_rst: 1'b1, ddr_reset_n: 1'b0, ddr_cke: 1'b0, init_done: 1'b0};

    // Counter only ever holds N-1, so clog2 of the largest count suffices; keep at least 1 bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

    function automatic pins_t decode_pins(input state_e s);
        pins_t p;
        p = PINS_RESET;
        case (s)
            ST_CKE_WAIT: p.ddr_reset_n = 1'b1;
            ST_RUN: begin
                p.ddr_reset_n = 1'b1;
                p.ddr_cke     = 1'b1;
                p.dram_rst    = 1'b0;
                p.init_done   = 1'b1;
            end
            default: p = PINS_RESET;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/dram_reset_sequencer_if.sv
// rtl/dram_reset_sequencer_if.sv - DRAM pin/status bundle; lock_lost exists only with DRAM_SEQ_LOCK_MONITOR_EN
interface dram_reset_sequencer_if;
    import dram_seq_pkg::*;

    logic   dram_rst;
    logic   ddr_reset_n;
    logic   ddr_cke;
    logic   init_done;
    state_e state;
`ifdef DRAM_SEQ_LOCK_MONITOR_EN
    logic   lock_lost;

    modport master (output dram_rst, ddr_reset_n, ddr_cke, init_done, state, lock_lost);
    modport slave  (input  dram_rst, ddr_reset_n, ddr_cke, init_done, state, lock_lost);
`else
    modport master (output dram_rst, ddr_reset_n, ddr_cke, init_done, state);
    modport slave  (input  dram_rst, ddr_reset_n, ddr_cke, init_done, state);
`endif

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous bit, resets to 0
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/dram_reset_sequencer.sv
// rtl/dram_reset_sequencer.sv - DDR3 power-up reset/CKE sequencer gated on PLL lock
// Optional DRAM_SEQ_LOCK_MONITOR_EN: lock loss after LOCK_WAIT aborts to IDLE and sets sticky lock_lost.
module dram_reset_sequencer
    import dram_seq_pkg::*;
#(
    parameter int LOCK_CYCLES  = DEF_LOCK_CYCLES,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int CKE_CYCLES   = DEF_CKE_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pll_locked,
    input  logic                          restart,
    dram_reset_sequencer_if.master        seq
);

    if (LOCK_CYCLES < 1 || RESET_CYCLES < 1 || CKE_CYCLES < 1) begin : g_param_check
        $error("dram_reset_sequencer: all cycle parameters must be >= 1");
    end

    localparam int CNT_W = cnt_width(LOCK_CYCLES, RESET_CYCLES, CKE_CYCLES);
    localparam logic [CNT_W-1:0] LOCK_LOAD  = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LOAD = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] CKE_LOAD   = CNT_W'(CKE_CYCLES - 1);

    logic             lock_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    pins_t            pins_q, pins_d;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pll_locked),
        .q_o   (lock_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (lock_s) begin
                    state_d = ST_LOCK_WAIT;
                    cnt_d   = LOCK_LOAD;
                end
            end
            ST_LOCK_WAIT: begin
                if (!lock_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_RESET_HOLD;
                    cnt_d   = RESET_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESET_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_CKE_WAIT;
                    cnt_d   = CKE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_CKE_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (restart) begin
                    state_d = ST_RESET_HOLD;
                    cnt_d   = RESET_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
`ifdef DRAM_SEQ_LOCK_MONITOR_EN
        // Placed after the case so lock loss overrides a same-cycle restart.
        if (!lock_s && (state_q inside {ST_RESET_HOLD, ST_CKE_WAIT, ST_RUN})) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
`endif
        pins_d = decode_pins(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pins_q  <= PINS_RESET;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pins_q  <= pins_d;
        end
    end

`ifdef DRAM_SEQ_LOCK_MONITOR_EN
    logic lock_lost_q, lock_lost_d;

    always_comb begin
        lock_lost_d = lock_lost_q;
        if (!lock_s && (state_q inside {ST_RESET_HOLD, ST_CKE_WAIT, ST_RUN})) begin
            lock_lost_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_lost_q <= 1'b0;
        end else begin
            lock_lost_q <= lock_lost_d;
        end
    end

    assign seq.lock_lost = lock_lost_q;
`endif

    assign seq.dram_rst    = pins_q.dram_rst;
    assign seq.ddr_reset_n = pins_q.ddr_reset_n;
    assign seq.ddr_cke     = pins_q.ddr_cke;
    assign seq.init_done   = pins_q.init_done;
    assign seq.state       = state_q;

endmodule

// File: tb/tb_dram_reset_sequencer.sv
// tb/tb_dram_reset_sequencer.sv - directed-vector bench for dram_reset_sequencer (DRAM_SEQ_LOCK_MONITOR_EN adds lock-loss vectors)
module tb_dram_reset_sequencer;

    localparam logic [31:0] S_IDLE  = 32'd0;
    localparam logic [31:0] S_LOCKW = 32'd1;
    localparam logic [31:0] S_HOLD  = 32'd2;
    localparam logic [31:0] S_CKEW  = 32'd3;
    localparam logic [31:0] S_RUN   = 32'd4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pll_locked = 1'b0;
    logic restart = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dram_reset_sequencer_if sm_if ();
    dram_reset_sequencer_if big_if ();

    dram_reset_sequencer #(
        .LOCK_CYCLES  (4),
        .RESET_CYCLES (8),
        .CKE_CYCLES   (16)
    ) u_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .restart    (restart),
        .seq        (sm_if)
    );

    dram_reset_sequencer u_default (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .restart    (restart),
        .seq        (big_if)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after the edge at which lock/reset-release was applied (E).
    task automatic seq_checks(input string tag);
        tick(2);
        check_val({tag, " E+2 state"}, 32'(sm_if.state), S_IDLE);
        tick(1);
        check_val({tag, " E+3 state"}, 32'(sm_if.state), S_LOCKW);
        check_val({tag, " E+3 reset_n"}, 32'(sm_if.ddr_reset_n), 32'd0);
        tick(3);
        check_val({tag, " E+6 state"}, 32'(sm_if.state), S_LOCKW);
        tick(1);
        check_val({tag, " E+7 state"}, 32'(sm_if.state), S_HOLD);
        tick(7);
        check_val({tag, " E+14 reset_n"}, 32'(sm_if.ddr_reset_n), 32'd0);
        tick(1);
        check_val({tag, " E+15 reset_n"}, 32'(sm_if.ddr_reset_n), 32'd1);
        check_val({tag, " E+15 state"}, 32'(sm_if.state), S_CKEW);
        check_val({tag, " E+15 cke"}, 32'(sm_if.ddr_cke), 32'd0);
        check_val({tag, " E+15 dram_rst"}, 32'(sm_if.dram_rst), 32'd1);
        tick(15);
        check_val({tag, " E+30 cke"}, 32'(sm_if.ddr_cke), 32'd0);
        check_val({tag, " E+30 init_done"}, 32'(sm_if.init_done), 32'd0);
        tick(1);
        check_val({tag, " E+31 cke"}, 32'(sm_if.ddr_cke), 32'd1);
        check_val({tag, " E+31 init_done"}, 32'(sm_if.init_done), 32'd1);
        check_val({tag, " E+31 dram_rst"}, 32'(sm_if.dram_rst), 32'd0);
        check_val({tag, " E+31 state"}, 32'(sm_if.state), S_RUN);
    endtask

    initial begin
        int wait_cnt;

        tick(2);
        check_val("rst state", 32'(sm_if.state), S_IDLE);
        check_val("rst dram_rst", 32'(sm_if.dram_rst), 32'd1);
        check_val("rst reset_n", 32'(sm_if.ddr_reset_n), 32'd0);
        check_val("rst cke", 32'(sm_if.ddr_cke), 32'd0);
        check_val("rst init_done", 32'(sm_if.init_done), 32'd0);

        rst_n = 1'b1;
        tick(4);
        check_val("idle no lock", 32'(sm_if.state), S_IDLE);

        pll_locked = 1'b1;
        seq_checks("boot");

        // restart from RUN
        tick(3);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        check_val("restart reset_n", 32'(sm_if.ddr_reset_n), 32'd0);
        check_val("restart cke", 32'(sm_if.ddr_cke), 32'd0);
        check_val("restart dram_rst", 32'(sm_if.dram_rst), 32'd1);
        check_val("restart init_done", 32'(sm_if.init_done), 32'd0);
        tick(7);
        check_val("restart R8 reset_n", 32'(sm_if.ddr_reset_n), 32'd0);
        tick(1);
        check_val("restart R9 reset_n", 32'(sm_if.ddr_reset_n), 32'd1);
        check_val("restart R9 state", 32'(sm_if.state), S_CKEW);

        // restart during CKE_WAIT must be ignored
        tick(3);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        check_val("ckew restart state", 32'(sm_if.state), S_CKEW);
        check_val("ckew restart reset_n", 32'(sm_if.ddr_reset_n), 32'd1);
        tick(11);
        check_val("ckew R24 cke", 32'(sm_if.ddr_cke), 32'd0);
        tick(1);
        check_val("ckew R25 cke", 32'(sm_if.ddr_cke), 32'd1);
        check_val("ckew R25 init_done", 32'(sm_if.init_done), 32'd1);

        // async reset in CKE_WAIT
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        tick(10);
        check_val("pre-abort state", 32'(sm_if.state), S_CKEW);
        rst_n = 1'b0;
        #1;
        check_val("abort state", 32'(sm_if.state), S_IDLE);
        check_val("abort reset_n", 32'(sm_if.ddr_reset_n), 32'd0);
        check_val("abort dram_rst", 32'(sm_if.dram_rst), 32'd1);
        check_val("abort cke", 32'(sm_if.ddr_cke), 32'd0);
        tick(2);
        rst_n = 1'b1;
        seq_checks("rerun");

        // brief lock during LOCK_WAIT
        rst_n = 1'b0;
        pll_locked = 1'b0;
        tick(2);
        rst_n = 1'b1;
        pll_locked = 1'b1;
        tick(2);
        pll_locked = 1'b0;
        tick(2);
        check_val("blip F4 state", 32'(sm_if.state), S_LOCKW);
        tick(1);
        check_val("blip F5 state", 32'(sm_if.state), S_IDLE);
        check_val("blip F5 reset_n", 32'(sm_if.ddr_reset_n), 32'd0);
        tick(5);
        check_val("blip F10 state", 32'(sm_if.state), S_IDLE);
        check_val("blip F10 reset_n", 32'(sm_if.ddr_reset_n), 32'd0);
        pll_locked = 1'b1;
        seq_checks("relock");

`ifdef DRAM_SEQ_LOCK_MONITOR_EN
        tick(2);
        check_val("mon pre lock_lost", 32'(sm_if.lock_lost), 32'd0);
        pll_locked = 1'b0;
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        tick(2);
        check_val("mon drop state", 32'(sm_if.state), S_IDLE);
        check_val("mon drop lock_lost", 32'(sm_if.lock_lost), 32'd1);
        check_val("mon drop dram_rst", 32'(sm_if.dram_rst), 32'd1);
        pll_locked = 1'b1;
        tick(40);
        check_val("mon sticky lock_lost", 32'(sm_if.lock_lost), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("mon rst lock_lost", 32'(sm_if.lock_lost), 32'd0);
`endif

        // default parameters: lock-to-dram_rst release latency
        rst_n = 1'b0;
        pll_locked = 1'b0;
        tick(2);
        rst_n = 1'b1;
        pll_locked = 1'b1;
        wait_cnt = 0;
        while (big_if.dram_rst && wait_cnt < 70000) begin
            tick(1);
            wait_cnt++;
        end
        check_val("default lock->dram_rst", 32'(wait_cnt), 32'd61003);
        check_val("default init_done", 32'(big_if.init_done), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dram_reset_sequencer.md
DRAM_RESET_SEQUENCER -- requirements
Module: dram_reset_sequencer

Interface
REQ-001 Parameter LOCK_CYCLES, default 1000, meaning cycles pll_locked must stay high before sequencing starts.
REQ-002 Parameter RESET_CYCLES, default 20000, meaning cycles ddr_reset_n is held low (200 us at 100 MHz).
REQ-003 Parameter CKE_CYCLES, default 40000, meaning cycles from ddr_reset_n release to ddr_cke assertion (400 us at 100 MHz).
REQ-004 clk  input  1  single clock, 100 MHz nominal; all logic in this domain.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 pll_locked  input  1  PLL lock indication, asynchronous to clk.
REQ-007 restart  input  1  single-cycle request to rerun DRAM reset from RUN.
REQ-008 dram_rst  output  1  synchronous reset for the dramsync domain, active-high.
REQ-009 ddr_reset_n  output  1  DDR3 RESET# pin drive.
REQ-010 ddr_cke  output  1  DDR3 CKE pin drive.
REQ-011 init_done  output  1  high only in RUN.
REQ-012 state  output  3  current state encoding (package enum).

Function
REQ-013 pll_locked SHALL pass through a 2-FF synchronizer; all uses below refer to the synchronized value (lock_s).
REQ-014 FSM states SHALL be IDLE, LOCK_WAIT, RESET_HOLD, CKE_WAIT, RUN.
REQ-015 IDLE: lock_s=1 -> LOCK_WAIT with counter loaded to LOCK_CYCLES-1.
REQ-016 LOCK_WAIT: counter decrements each cycle; lock_s=0 -> IDLE; counter==0 with lock_s=1 -> RESET_HOLD, counter loaded RESET_CYCLES-1.
REQ-017 RESET_HOLD: at counter==0 -> CKE_WAIT, counter loaded CKE_CYCLES-1; otherwise decrement.
REQ-018 CKE_WAIT: at counter==0 -> RUN; otherwise decrement.
REQ-019 RUN: restart=1 -> RESET_HOLD, counter loaded RESET_CYCLES-1; RUN otherwise terminal.
REQ-020 restart SHALL be ignored outside RUN.
REQ-021 Outputs SHALL be registered, decoded from next state: IDLE/LOCK_WAIT/RESET_HOLD -> ddr_reset_n=0, ddr_cke=0, dram_rst=1; CKE_WAIT -> ddr_reset_n=1, ddr_cke=0, dram_rst=1; RUN -> ddr_reset_n=1, ddr_cke=1, dram_rst=0, init_done=1.
REQ-022 ddr_reset_n SHALL be low for exactly RESET_CYCLES cycles in RESET_HOLD; ddr_cke SHALL assert exactly CKE_CYCLES cycles after ddr_reset_n rises.
REQ-023 Counter width SHALL be $clog2(max(LOCK_CYCLES,RESET_CYCLES,CKE_CYCLES)); counter never wraps.
REQ-024 Any parameter < 1 SHALL cause an elaboration error.
REQ-025 With defaults, dram_rst SHALL deassert 61002..61004 cycles after lock (within 600-700 us window at 100 MHz).

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, counter=0, sync FFs=0, dram_rst=1, ddr_reset_n=0, ddr_cke=0, init_done=0, lock_lost=0.
REQ-027 rst_n asserted mid-sequence SHALL abort; on release the sequence restarts from IDLE.

Configuration
REQ-028 Macro DRAM_SEQ_LOCK_MONITOR_EN defined: lock_s=0 in RESET_HOLD, CKE_WAIT or RUN SHALL force IDLE next cycle and set sticky output lock_lost (1 bit, cleared only by rst_n); lock loss wins over simultaneous restart.
REQ-029 Macro undefined: lock_s ignored after LOCK_WAIT; lock_lost port absent.

Structure
REQ-030 Package dram_seq_pkg SHALL hold the state enum (3-bit) and default cycle constants.
REQ-031 Synchronizer SHALL be sub-module sync_2ff (parameterless, 1 bit, reset to 0).

Verification
REQ-032 LOCK=4,RESET=8,CKE=16; lock high at cycle 10 -> ddr_reset_n rises cycle 24±1, ddr_cke and init_done rise 16 cycles later, dram_rst falls same cycle.
REQ-033 Lock high 2 cycles then low during LOCK_WAIT -> returns IDLE, ddr_reset_n stays 0, full LOCK_WAIT repeated on next lock.
REQ-034 restart pulse in RUN -> next cycle ddr_reset_n=0, ddr_cke=0, dram_rst=1, init_done=0; held 8 cycles, then full CKE_WAIT of 16.
REQ-035 restart pulse during CKE_WAIT -> no effect, timing unchanged.
REQ-036 rst_n pulsed low in CKE_WAIT -> outputs reset asynchronously; complete sequence reruns after release.
REQ-037 DRAM_SEQ_LOCK_MONITOR_EN set, lock dropped in RUN -> IDLE within 3 cycles, lock_lost=1 until rst_n; defaults: dram_rst falls between 600 us and 700 us.
